// File: rtl/db_pkg.sv
// Shared constants for the four-channel push-button debouncer.
// Optional 2-flop input synchronizer is enabled by defining DB_SYNC_EN.
package db_pkg;

    // Default number of consecutive stable samples before an output follows
    localparam int DB_CYCLES_DEF = 8;

    // Number of button channels handled by btn_debounce
    localparam int NUM_BTN = 4;

    // Channel positions inside the packed button/output vectors
    localparam int CH_HS      = 0;
    localparam int CH_VS      = 1;
    localparam int CH_DF_UART = 2;
    localparam int CH_DF_VGA  = 3;

    // Counter width able to hold values 0..cycles
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/db_channel.sv
// One debounce channel: optional 2-flop synchronizer, stability counter, output flop.
// With DB_SYNC_EN undefined the filter samples the raw (already synchronous) input.
import db_pkg::*;

module db_channel #(
    parameter int DEBOUNCE_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             filt;
    logic [CNT_W-1:0] cnt;

`ifdef DB_SYNC_EN
    logic s1;
    logic s2;

    // Two-stage synchronizer for the asynchronous button input
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    assign filt = s2;
`else
    assign filt = btn;
`endif

    // Count consecutive samples that differ from the output; follow after a full run
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (filt == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= filt;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Four-channel push-button debouncer for the Color_Show board design.
// Define DB_SYNC_EN to add a 2-flop synchronizer in front of every channel.
import db_pkg::*;

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btnHS,
    input  logic btnVS,
    input  logic btnDF_UART,
    input  logic btnDF_VGA,
    output logic HS,
    output logic VS,
    output logic DF_UART,
    output logic DF_VGA
);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] clean;

    assign raw[CH_HS]      = btnHS;
    assign raw[CH_VS]      = btnVS;
    assign raw[CH_DF_UART] = btnDF_UART;
    assign raw[CH_DF_VGA]  = btnDF_VGA;

    db_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_hs (
        .clk  (clk),
        .rst  (rst),
        .btn  (raw[CH_HS]),
        .level(clean[CH_HS])
    );

    db_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_vs (
        .clk  (clk),
        .rst  (rst),
        .btn  (raw[CH_VS]),
        .level(clean[CH_VS])
    );

    db_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_df_uart (
        .clk  (clk),
        .rst  (rst),
        .btn  (raw[CH_DF_UART]),
        .level(clean[CH_DF_UART])
    );

    db_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_df_vga (
        .clk  (clk),
        .rst  (rst),
        .btn  (raw[CH_DF_VGA]),
        .level(clean[CH_DF_VGA])
    );

    assign HS      = clean[CH_HS];
    assign VS      = clean[CH_VS];
    assign DF_UART = clean[CH_DF_UART];
    assign DF_VGA  = clean[CH_DF_VGA];

endmodule

// File: tb/tb_btn_debounce.sv
// Testbench for btn_debounce: directed scenarios plus randomized stimulus vs a window model.
// Latency expectations follow DB_SYNC_EN (N+2 edges when defined, N otherwise).
module tb_btn_debounce;

    localparam int N = 8;
`ifdef DB_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT = N + SYNC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] btn = 4'b0;
    logic HS, VS, DF_UART, DF_VGA;
    logic [3:0] dout;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: output levels, input delay line, filter sample history
    logic [3:0] m_out = 4'b0;
    logic [3:0] p1 = 4'b0;
    logic [3:0] p2 = 4'b0;
    logic [3:0] samp[$];
    int since[4];

    btn_debounce #(.DEBOUNCE_CYCLES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .btnHS     (btn[0]),
        .btnVS     (btn[1]),
        .btnDF_UART(btn[2]),
        .btnDF_VGA (btn[3]),
        .HS        (HS),
        .VS        (VS),
        .DF_UART   (DF_UART),
        .DF_VGA    (DF_VGA)
    );

    assign dout = {DF_VGA, DF_UART, VS, HS};

    always #2 clk = ~clk;

    // Output flips once the last N filter samples since the last change all differ from it
    task automatic model_edge(input logic r, input logic [3:0] b);
        logic [3:0] f;
        int t;
        bit all_diff;
        if (r) begin
            m_out = '0;
            p1 = '0;
            p2 = '0;
            samp.delete();
            for (int c = 0; c < 4; c++) since[c] = 0;
        end else begin
            f = (SYNC == 2) ? p2 : b;
            p2 = p1;
            p1 = b;
            samp.push_back(f);
            t = samp.size() - 1;
            for (int c = 0; c < 4; c++) begin
                if (t - since[c] + 1 >= N) begin
                    all_diff = 1'b1;
                    for (int j = t - N + 1; j <= t; j++)
                        if (samp[j][c] == m_out[c]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_out[c] = ~m_out[c];
                        since[c] = t + 1;
                    end
                end
            end
        end
    endtask

    task automatic tick(input logic r, input logic [3:0] b);
        rst = r;
        btn = b;
        @(posedge clk);
        model_edge(r, b);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 4'hF);
            n_tests++;
            if (dout !== 4'b0) begin
                n_fail++;
                $display("FAIL reset_hold edge=%0d got=%b exp=0000", i, dout);
            end
        end
        tick(1'b0, 4'hF);
        n_tests++;
        if (dout !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_release got=%b exp=0000", dout);
        end
        tick(1'b1, 4'h0);
    endtask

    task automatic test_bounce;
        tick(1'b1, 4'h0);
        for (int i = 0; i < 8 + 12; i++) begin
            tick(1'b0, {3'b0, (i < 8) ? i[0] : 1'b0});
            n_tests++;
            if (HS !== 1'b0 || dout !== m_out) begin
                n_fail++;
                $display("FAIL bounce i=%0d got=%b exp=%b", i, dout, m_out);
            end
        end
    endtask

    task automatic test_clean_press;
        int rise = 0;
        tick(1'b1, 4'h0);
        for (int i = 1; i <= 15; i++) begin
            tick(1'b0, 4'b0001);
            if (HS === 1'b1 && rise == 0) rise = i;
            n_tests++;
            if (HS !== (i >= LAT) || dout !== m_out) begin
                n_fail++;
                $display("FAIL press_level i=%0d got=%b exp=%b", i, dout, m_out);
            end
        end
        n_tests++;
        if (rise != LAT) begin
            n_fail++;
            $display("FAIL press_edge got=%0d exp=%0d", rise, LAT);
        end
    endtask

    task automatic test_glitch;
        int fall = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, (i < 4) ? 4'b0000 : 4'b0001);
            n_tests++;
            if (HS !== 1'b1 || dout !== m_out) begin
                n_fail++;
                $display("FAIL glitch_hold i=%0d got=%b exp=%b", i, dout, m_out);
            end
        end
        for (int i = 1; i <= 12; i++) begin
            tick(1'b0, 4'b0000);
            if (HS === 1'b0 && fall == 0) fall = i;
        end
        n_tests++;
        if (fall != LAT || HS !== 1'b0) begin
            n_fail++;
            $display("FAIL release_edge got=%0d exp=%0d", fall, LAT);
        end
    endtask

    task automatic test_isolation;
        int rise = 0;
        tick(1'b1, 4'h0);
        for (int i = 1; i <= 12; i++) begin
            tick(1'b0, 4'b0010);
            if (VS === 1'b1 && rise == 0) rise = i;
            n_tests++;
            if ((dout & 4'b1101) !== 4'b0) begin
                n_fail++;
                $display("FAIL isolation i=%0d got=%b exp=0000 on HS/DF", i, dout);
            end
        end
        n_tests++;
        if (rise != LAT) begin
            n_fail++;
            $display("FAIL vs_edge got=%0d exp=%0d", rise, LAT);
        end
    endtask

    task automatic test_reset_mid;
        int rise = 0;
        tick(1'b1, 4'h0);
        for (int i = 0; i < 6; i++) tick(1'b0, 4'b1000);
        tick(1'b1, 4'b1000);
        n_tests++;
        if (DF_VGA !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear got=%b exp=0", DF_VGA);
        end
        for (int i = 1; i <= 12; i++) begin
            tick(1'b0, 4'b1000);
            if (DF_VGA === 1'b1 && rise == 0) rise = i;
        end
        n_tests++;
        if (rise != LAT) begin
            n_fail++;
            $display("FAIL midreset_edge got=%0d exp=%0d", rise, LAT);
        end
    endtask

    task automatic test_random;
        logic [3:0] v;
        int len;
        logic r;
        tick(1'b1, 4'h0);
        for (int seg = 0; seg < 150; seg++) begin
            v = 4'($urandom);
            len = $urandom_range(1, N + 6);
            r = ($urandom_range(0, 39) == 0);
            for (int k = 0; k < len; k++) begin
                tick((k == 0) ? r : 1'b0, v);
                n_tests++;
                if (dout !== m_out) begin
                    n_fail++;
                    $display("FAIL random seg=%0d k=%0d got=%b exp=%b", seg, k, dout, m_out);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_clean_press();
        test_glitch();
        test_isolation();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
